// File: rtl/vga_pkg.sv
// Shared timing constants, colour type and the cell address helper for the VGA scan-out path.
package vga_pkg;

  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int LOG_W = 160;
  localparam int LOG_H = 120;

  typedef logic [COLOUR_W-1:0] colour_t;

  // y*160 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
    cell_addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus the DE2 VGA DAC pins and the frame strobe.
interface vga_scanout_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  colour_t           rd_data;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;
  logic              vga_hs;
  logic              vga_vs;
  logic              vga_blank_n;
  logic              vga_sync_n;
  logic              vga_clk;
  logic              frame_start;

  modport master (
    output rd_addr,
    input  rd_data,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
    output frame_start
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
    input  frame_start
  );

endinterface

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters and the combinational sync/visible decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int P_H_VIS  = H_VIS,
  parameter int P_H_FP   = H_FP,
  parameter int P_H_SYNC = H_SYNC,
  parameter int P_H_BP   = H_BP,
  parameter int P_V_VIS  = V_VIS,
  parameter int P_V_FP   = V_FP,
  parameter int P_V_SYNC = V_SYNC,
  parameter int P_V_BP   = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_pix_en,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_vis,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_frame_pt
);

  localparam logic [9:0] H_LAST   = 10'(P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [9:0] H_VISL   = 10'(P_H_VIS);
  localparam logic [9:0] HS_START = 10'(P_H_VIS + P_H_FP);
  localparam logic [9:0] HS_END   = 10'(P_H_VIS + P_H_FP + P_H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP - 1);
  localparam logic [9:0] V_VISL   = 10'(P_V_VIS);
  localparam logic [9:0] VS_START = 10'(P_V_VIS + P_V_FP);
  localparam logic [9:0] VS_END   = 10'(P_V_VIS + P_V_FP + P_V_SYNC);

  logic       r_pix_en;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_en <= 1'b0;
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Each logical cell covers 4x4 pixels, so the low two counter bits are dropped.
  assign o_pix_en   = r_pix_en;
  assign o_x        = r_h_cnt[9:2];
  assign o_y        = r_v_cnt[8:2];
  assign o_vis      = (r_h_cnt < H_VISL) && (r_v_cnt < V_VISL);
  assign o_hs       = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign o_vs       = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
  assign o_frame_pt = (r_h_cnt == 10'd0) && (r_v_cnt == V_VISL);

endmodule

// File: rtl/vga_scanout.sv
// Reads the 160x120 framebuffer and drives the VGA DAC through a two-tick pipeline.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  logic       w_pix_en;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic       w_vis;
  logic       w_hs;
  logic       w_vs;
  logic       w_frame_pt;

  vga_timing #(
    .P_H_VIS(H_VIS), .P_H_FP(H_FP), .P_H_SYNC(H_SYNC), .P_H_BP(H_BP),
    .P_V_VIS(V_VIS), .P_V_FP(V_FP), .P_V_SYNC(V_SYNC), .P_V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .o_pix_en  (w_pix_en),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_vis     (w_vis),
    .o_hs      (w_hs),
    .o_vs      (w_vs),
    .o_frame_pt(w_frame_pt)
  );

  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_vis1;
  logic              r_hs1;
  logic              r_vs1;
  logic [2:0][7:0]   r_dac;
  logic              r_hs;
  logic              r_vs;
  logic              r_blank_n;
  logic              r_frame_start;
  logic [2:0][7:0]   w_dac;
  colour_t           w_colour;

  assign w_colour = bus.rd_data;

  // Channel order matches the framebuffer word {r,g,b}; blanking forces black.
  generate
    for (genvar gi = 0; gi < COLOUR_W; gi++) begin : g_chan
      assign w_dac[gi] = {8{w_colour[gi] & r_vis1}};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr     <= '0;
      r_vis1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_dac         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en & w_frame_pt;
      if (w_pix_en) begin
        // Holding the address in blanking keeps it inside the 19200-cell buffer.
        if (w_vis) begin
          r_rd_addr <= cell_addr(w_x, w_y);
        end
        r_vis1    <= w_vis;
        r_hs1     <= w_hs;
        r_vs1     <= w_vs;
        r_dac     <= w_dac;
        r_hs      <= r_hs1;
        r_vs      <= r_vs1;
        r_blank_n <= r_vis1;
      end
    end
  end

  assign bus.rd_addr     = r_rd_addr;
  assign bus.vga_r       = r_dac[2];
  assign bus.vga_g       = r_dac[1];
  assign bus.vga_b       = r_dac[0];
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_clk     = w_pix_en;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-timing instance for line/address/colour checks, short-frame instance for vertical checks.
module tb_vga_scanout;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  vga_scanout_if bus_a ();
  vga_scanout_if bus_b ();

  vga_scanout u_a (.clk(clk), .reset(rst), .bus(bus_a));
  vga_scanout #(.V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_b (.clk(clk), .reset(rst), .bus(bus_b));

  logic [2:0] mem [0:19199];
  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 3'((i % 7) + 1);
    mem[161] = 3'b101;
  end

  always @(posedge clk) begin
    bus_a.rd_data <= mem[bus_a.rd_addr];
    bus_b.rd_data <= mem[bus_b.rd_addr];
  end

  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int fs_cnt = 0;
  always @(negedge clk) if (bus_b.frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, blank;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the k-th clock edge since reset release.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rd_addr for raster position p is visible after edge 2p+2, the DAC pins after 2p+4.
  task automatic check_pos(input int p);
    int h, v;
    logic vis;
    logic [2:0] c;
    exp_t e, o;
    h   = p % 800;
    v   = p / 800;
    vis = (h < 640) && (v < 480);
    goto(2 * p + 2);
    if (vis) chk($sformatf("rd_addr(%0d,%0d)", h, v), 32'(bus_a.rd_addr), 32'((v / 4) * 160 + h / 4));
    c       = vis ? mem[(v / 4) * 160 + h / 4] : 3'b000;
    e.r     = c[2] ? 8'hFF : 8'h00;
    e.g     = c[1] ? 8'hFF : 8'h00;
    e.b     = c[0] ? 8'hFF : 8'h00;
    e.hs    = !(h >= 656 && h < 752);
    e.blank = vis;
    sb_q.push_back(e);
    goto(2 * p + 4);
    o = sb_q.pop_front();
    chk($sformatf("vga_r(%0d,%0d)", h, v), 32'(bus_a.vga_r), 32'(o.r));
    chk($sformatf("vga_g(%0d,%0d)", h, v), 32'(bus_a.vga_g), 32'(o.g));
    chk($sformatf("vga_b(%0d,%0d)", h, v), 32'(bus_a.vga_b), 32'(o.b));
    chk($sformatf("hs(%0d,%0d)", h, v), 32'(bus_a.vga_hs), 32'(o.hs));
    chk($sformatf("blank_n(%0d,%0d)", h, v), 32'(bus_a.vga_blank_n), 32'(o.blank));
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
    chk("rst_hs", 32'(bus_a.vga_hs), 32'd1);
    chk("rst_vs", 32'(bus_a.vga_vs), 32'd1);
    chk("rst_blank_n", 32'(bus_a.vga_blank_n), 32'd0);
    chk("rst_rgb", 32'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}), 32'd0);
    chk("rst_vga_clk", 32'(bus_a.vga_clk), 32'd0);
    chk("rst_sync_n", 32'(bus_a.vga_sync_n), 32'd0);
    chk("rst_frame_start", 32'(bus_b.frame_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    goto(1);
    chk("pix_en_after_clk1", 32'(bus_a.vga_clk), 32'd1);
    goto(3);
    chk("blank_n_before_latency", 32'(bus_a.vga_blank_n), 32'd0);
    for (int p = 0; p < 4; p++) check_pos(p);

    goto(1283); chk("blank_n_h639", 32'(bus_a.vga_blank_n), 32'd1);
    goto(1284); chk("blank_n_h640", 32'(bus_a.vga_blank_n), 32'd0);
    goto(1315); chk("hs_h655", 32'(bus_a.vga_hs), 32'd1);
    goto(1316); chk("hs_h656", 32'(bus_a.vga_hs), 32'd0);
    goto(1507); chk("hs_h751", 32'(bus_a.vga_hs), 32'd0);
    goto(1508); chk("hs_h752", 32'(bus_a.vga_hs), 32'd1);
    goto(1603); chk("blank_n_line0_end", 32'(bus_a.vga_blank_n), 32'd0);
    goto(1604); chk("blank_n_line1_start", 32'(bus_a.vga_blank_n), 32'd1);

    check_pos(1 * 800 + 639);
    check_pos(1 * 800 + 700);
    chk("rd_addr_hold_blank", 32'(bus_a.rd_addr), 32'd159);
    check_pos(4 * 800 + 4);
    check_pos(4 * 800 + 639);
    chk("addr_fn_last_cell", 32'(cell_addr(8'd159, 7'd119)), 32'd19199);

    goto(12801); chk("fs_before", 32'(bus_b.frame_start), 32'd0);
    goto(12802); chk("fs_pulse1", 32'(bus_b.frame_start), 32'd1);
    goto(12803); chk("fs_width", 32'(bus_b.frame_start), 32'd0);
    goto(16003); chk("vs_before", 32'(bus_b.vga_vs), 32'd1);
    goto(16004); chk("vs_fall", 32'(bus_b.vga_vs), 32'd0);
    goto(19203); chk("vs_last_low", 32'(bus_b.vga_vs), 32'd0);
    goto(19204); chk("vs_rise", 32'(bus_b.vga_vs), 32'd1);
    goto(36801); chk("fs2_before", 32'(bus_b.frame_start), 32'd0);
    goto(36802); chk("fs_pulse2", 32'(bus_b.frame_start), 32'd1);
    goto(36804); chk("fs_count", 32'(fs_cnt), 32'd2);

    goto(39000);
    chk("pre_reset_blank_n", 32'(bus_a.vga_blank_n), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_addr", 32'(bus_a.rd_addr), 32'd0);
    chk("mid_rst_hs", 32'(bus_a.vga_hs), 32'd1);
    chk("mid_rst_vs", 32'(bus_a.vga_vs), 32'd1);
    chk("mid_rst_blank_n", 32'(bus_a.vga_blank_n), 32'd0);
    chk("mid_rst_rgb", 32'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}), 32'd0);
    chk("mid_rst_vga_clk", 32'(bus_a.vga_clk), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    goto(12801); chk("fs_after_rst_before", 32'(bus_b.frame_start), 32'd0);
    goto(12802); chk("fs_after_rst", 32'(bus_b.frame_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
